idex_stage_reg: RTL and testbench
=================================

# idex_stage_reg

ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection. It latches decoded operands, register indices and control from ID, and drives the `IDtoEX_*` fields consumed by EX and by the forwarding logic. It inserts a one-cycle bubble on a load-use hazard, applies branch/jump flushes, and honours a downstream hold. A saturating counter records the number of inserted load-use bubbles.

## Interface
Parameters:
- `CTRL_W`, 16: width of opaque EX/MEM/WB control bundle (ALUFun, ALUSrc, MemtoReg, ...).

Ports:
- `clk`  in  1  core clock; all registers update on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ID_PC`  in  32  PC+4 of instruction in ID.
- `ID_RegRs`, `ID_RegRt`  in  5 each  source register indices.
- `ID_RegRd`  in  5  resolved destination index (after RegDst mux).
- `ID_DataA`, `ID_DataB`  in  32 each  register-file read data.
- `ID_Imm`  in  32  extended immediate.
- `ID_Ctrl`  in  CTRL_W  control bundle.
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`  in  1 each  explicit control bits.
- `Flush`  in  1  wrong-path kill of the ID instruction (taken branch/jump).
- `Hold`  in  1  downstream stall; freeze this stage.
- `IDtoEX_PC`, `IDtoEX_DataA`, `IDtoEX_DataB`, `IDtoEX_Imm`  out  32 each  registered copies.
- `IDtoEX_RegRs`, `IDtoEX_RegRt`, `IDtoEX_RegRd`  out  5 each  registered indices.
- `IDtoEX_Ctrl`  out  CTRL_W  registered control.
- `IDtoEX_RegWrite`, `IDtoEX_MemRead`, `IDtoEX_MemWrite`  out  1 each.
- `IDtoEX_Valid`  out  1  1 = real instruction, 0 = bubble.
- `Stall_IFID`  out  1  combinational; freeze PC and IF/ID register.
- `BubbleCount`  out  16  saturating count of load-use bubbles.

## Operation
- Reset (`reset`=0): every output register is cleared to 0, including `IDtoEX_Valid` and `BubbleCount`.
- Hazard term `LU` = `IDtoEX_MemRead` && `IDtoEX_RegRd`!=0 && (`IDtoEX_RegRd`==`ID_RegRs` || `IDtoEX_RegRd`==`ID_RegRt`).
- Per-edge action, in priority order:
  1. `Flush`=1: load a bubble.
  2. `Hold`=1: keep all registers unchanged.
  3. `LU`=1: load a bubble and increment `BubbleCount`.
  4. Otherwise: load all ID inputs and set `IDtoEX_Valid`=1.
- Bubble: all output registers are 0. RegRs/RegRt/RegRd = 0 guarantees no forwarding match and no write.
- `Stall_IFID` = `Hold` || (`LU` && !`Flush`). `Flush` overrides: the ID instruction is wrong-path, so there is no stall.
- `BubbleCount` saturates at 0xFFFF and does not change on flush or hold.

## Timing
- Latency: 1 cycle from ID inputs to `IDtoEX_*`.
- `Stall_IFID` is combinational from the current register state, ID inputs, `Flush` and `Hold`. It has no internal registered delay.
- A load-use stall lasts exactly 1 cycle. After the bubble, `IDtoEX_MemRead`=0, so `LU` drops and the held instruction loads on the next edge.
- `Hold` across a pending `LU`: registers are frozen and `Stall_IFID`=1; the bubble is inserted on the first edge where `Hold`=0.
- Reset asserted mid-stall: outputs clear immediately and `Stall_IFID` drops, because the cleared `IDtoEX_MemRead` is 0.

## Configuration
- `LOAD_USE_DETECT_EN` defined: behaviour as above.
- Not defined: `LU` is tied to 0, `Stall_IFID` = `Hold`, and `BubbleCount` is held at 0. The external hazard unit or the compiler is then responsible for load-use spacing.

## Test plan
- Reset: drive ID inputs nonzero with `reset`=0 -> all outputs 0, `Valid`=0; release -> next edge loads inputs, `Valid`=1.
- Load-use: EX holds `lw $8` (MemRead=1, Rd=8) while ID has Rs=8 -> `Stall_IFID`=1, next edge yields a bubble with `BubbleCount`=1; following edge loads the ID instruction with `Stall_IFID`=0.
- Rd=0 load: `lw $0` then ID Rs=0 -> no stall, `BubbleCount` unchanged.
- Flush+LU same cycle: `Flush`=1 with the hazard condition present -> bubble loaded, `Stall_IFID`=0, `BubbleCount` unchanged.
- Hold: `Hold`=1 for 3 cycles with changing ID inputs -> outputs constant and `Stall_IFID`=1; release -> normal load.
- Saturation (macro on): force 65537 hazards -> `BubbleCount`=0xFFFF. Macro off: the same stimulus gives `Stall_IFID`=0 and count 0.

Source files
------------

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble counter.
// Ports: clk, reset (async active-low); ID_* operands/control in; Flush, Hold in;
//   IDtoEX_* registered operands/control/Valid out; Stall_IFID (combinational)
//   out; BubbleCount (saturating count of load-use bubbles) out.
// Optional feature: define LOAD_USE_DETECT_EN to enable load-use detection.
//   Without it, LU is tied off, Stall_IFID follows Hold and BubbleCount stays 0.
module idex_stage_reg #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ID_PC,
    input  logic [4:0]        ID_RegRs,
    input  logic [4:0]        ID_RegRt,
    input  logic [4:0]        ID_RegRd,
    input  logic [31:0]       ID_DataA,
    input  logic [31:0]       ID_DataB,
    input  logic [31:0]       ID_Imm,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              Flush,
    input  logic              Hold,
    output logic [31:0]       IDtoEX_PC,
    output logic [31:0]       IDtoEX_DataA,
    output logic [31:0]       IDtoEX_DataB,
    output logic [31:0]       IDtoEX_Imm,
    output logic [4:0]        IDtoEX_RegRs,
    output logic [4:0]        IDtoEX_RegRt,
    output logic [4:0]        IDtoEX_RegRd,
    output logic [CTRL_W-1:0] IDtoEX_Ctrl,
    output logic              IDtoEX_RegWrite,
    output logic              IDtoEX_MemRead,
    output logic              IDtoEX_MemWrite,
    output logic              IDtoEX_Valid,
    output logic              Stall_IFID,
    output logic [15:0]       BubbleCount
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [31:0]       data_a;
        logic [31:0]       data_b;
        logic [31:0]       imm;
        logic [CTRL_W-1:0] ctrl;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              valid;
    } idex_t;

    idex_t       stage_q;
    idex_t       stage_d;
    idex_t       id_in;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        lu;

    assign id_in = '{
        pc:        ID_PC,
        rs:        ID_RegRs,
        rt:        ID_RegRt,
        rd:        ID_RegRd,
        data_a:    ID_DataA,
        data_b:    ID_DataB,
        imm:       ID_Imm,
        ctrl:      ID_Ctrl,
        reg_write: ID_RegWrite,
        mem_read:  ID_MemRead,
        mem_write: ID_MemWrite,
        valid:     1'b1
    };

`ifdef LOAD_USE_DETECT_EN
    // A load in EX whose target is read by the instruction in ID.
    // $0 is never a real dependency.
    assign lu = stage_q.mem_read
             && (stage_q.rd != 5'd0)
             && (stage_q.rd == ID_RegRs || stage_q.rd == ID_RegRt);
`else
    assign lu = 1'b0;
`endif

    // A flushed ID instruction is wrong-path, so its hazard is irrelevant.
    assign Stall_IFID = Hold || (lu && !Flush);

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        priority case (1'b1)
            Flush: begin
                stage_d = '0;
            end
            Hold: begin
                stage_d = stage_q;
            end
            lu: begin
                stage_d = '0;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                stage_d = id_in;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IDtoEX_PC       = stage_q.pc;
    assign IDtoEX_DataA    = stage_q.data_a;
    assign IDtoEX_DataB    = stage_q.data_b;
    assign IDtoEX_Imm      = stage_q.imm;
    assign IDtoEX_RegRs    = stage_q.rs;
    assign IDtoEX_RegRt    = stage_q.rt;
    assign IDtoEX_RegRd    = stage_q.rd;
    assign IDtoEX_Ctrl     = stage_q.ctrl;
    assign IDtoEX_RegWrite = stage_q.reg_write;
    assign IDtoEX_MemRead  = stage_q.mem_read;
    assign IDtoEX_MemWrite = stage_q.mem_write;
    assign IDtoEX_Valid    = stage_q.valid;
    assign BubbleCount     = cnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Self-checking bench for idex_stage_reg.
// Expectations adapt to whether LOAD_USE_DETECT_EN is defined.
module tb_idex_stage_reg;

    localparam int CTRL_W = 16;
`ifdef LOAD_USE_DETECT_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       ID_PC = '0;
    logic [4:0]        ID_RegRs = '0;
    logic [4:0]        ID_RegRt = '0;
    logic [4:0]        ID_RegRd = '0;
    logic [31:0]       ID_DataA = '0;
    logic [31:0]       ID_DataB = '0;
    logic [31:0]       ID_Imm = '0;
    logic [CTRL_W-1:0] ID_Ctrl = '0;
    logic              ID_RegWrite = 1'b0;
    logic              ID_MemRead = 1'b0;
    logic              ID_MemWrite = 1'b0;
    logic              Flush = 1'b0;
    logic              Hold = 1'b0;
    logic [31:0]       IDtoEX_PC;
    logic [31:0]       IDtoEX_DataA;
    logic [31:0]       IDtoEX_DataB;
    logic [31:0]       IDtoEX_Imm;
    logic [4:0]        IDtoEX_RegRs;
    logic [4:0]        IDtoEX_RegRt;
    logic [4:0]        IDtoEX_RegRd;
    logic [CTRL_W-1:0] IDtoEX_Ctrl;
    logic              IDtoEX_RegWrite;
    logic              IDtoEX_MemRead;
    logic              IDtoEX_MemWrite;
    logic              IDtoEX_Valid;
    logic              Stall_IFID;
    logic [15:0]       BubbleCount;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       a;
        logic [31:0]       b;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
        logic              rw;
        logic              mr;
        logic              mw;
        logic              valid;
        logic [15:0]       cnt;
    } out_t;

    out_t        sb[$];
    out_t        exp_o;
    out_t        got;
    out_t        last;
    logic [15:0] exp_cnt = '0;
    int          checks = 0;
    int          errors = 0;

    idex_stage_reg #(.CTRL_W(CTRL_W)) dut (
        .clk(clk),
        .reset(reset),
        .ID_PC(ID_PC),
        .ID_RegRs(ID_RegRs),
        .ID_RegRt(ID_RegRt),
        .ID_RegRd(ID_RegRd),
        .ID_DataA(ID_DataA),
        .ID_DataB(ID_DataB),
        .ID_Imm(ID_Imm),
        .ID_Ctrl(ID_Ctrl),
        .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite),
        .Flush(Flush),
        .Hold(Hold),
        .IDtoEX_PC(IDtoEX_PC),
        .IDtoEX_DataA(IDtoEX_DataA),
        .IDtoEX_DataB(IDtoEX_DataB),
        .IDtoEX_Imm(IDtoEX_Imm),
        .IDtoEX_RegRs(IDtoEX_RegRs),
        .IDtoEX_RegRt(IDtoEX_RegRt),
        .IDtoEX_RegRd(IDtoEX_RegRd),
        .IDtoEX_Ctrl(IDtoEX_Ctrl),
        .IDtoEX_RegWrite(IDtoEX_RegWrite),
        .IDtoEX_MemRead(IDtoEX_MemRead),
        .IDtoEX_MemWrite(IDtoEX_MemWrite),
        .IDtoEX_Valid(IDtoEX_Valid),
        .Stall_IFID(Stall_IFID),
        .BubbleCount(BubbleCount)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic out_t sample();
        out_t o;
        o.pc    = IDtoEX_PC;
        o.a     = IDtoEX_DataA;
        o.b     = IDtoEX_DataB;
        o.imm   = IDtoEX_Imm;
        o.rs    = IDtoEX_RegRs;
        o.rt    = IDtoEX_RegRt;
        o.rd    = IDtoEX_RegRd;
        o.ctrl  = IDtoEX_Ctrl;
        o.rw    = IDtoEX_RegWrite;
        o.mr    = IDtoEX_MemRead;
        o.mw    = IDtoEX_MemWrite;
        o.valid = IDtoEX_Valid;
        o.cnt   = BubbleCount;
        return o;
    endfunction

    // Expected registered image of what the bench is currently driving.
    function automatic out_t id_image(input logic [15:0] cnt);
        out_t o;
        o.pc    = ID_PC;
        o.a     = ID_DataA;
        o.b     = ID_DataB;
        o.imm   = ID_Imm;
        o.rs    = ID_RegRs;
        o.rt    = ID_RegRt;
        o.rd    = ID_RegRd;
        o.ctrl  = ID_Ctrl;
        o.rw    = ID_RegWrite;
        o.mr    = ID_MemRead;
        o.mw    = ID_MemWrite;
        o.valid = 1'b1;
        o.cnt   = cnt;
        return o;
    endfunction

    function automatic out_t bubble(input logic [15:0] cnt);
        out_t o;
        o     = '0;
        o.cnt = cnt;
        return o;
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic mr,
                         input logic fl, input logic hd);
        ID_PC       = $urandom | 32'h1;
        ID_DataA    = $urandom;
        ID_DataB    = $urandom;
        ID_Imm      = $urandom;
        ID_Ctrl     = CTRL_W'($urandom);
        ID_RegWrite = 1'($urandom);
        ID_MemWrite = 1'($urandom);
        ID_RegRs    = rs;
        ID_RegRt    = rt;
        ID_RegRd    = rd;
        ID_MemRead  = mr;
        Flush       = fl;
        Hold        = hd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        got = sample();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        checks++;
        if (Stall_IFID !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=0", Stall_IFID);
        end
        reset   = 1'b1;
        exp_cnt = '0;
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", got, exp_o);
        end
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        last  = got;
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL reset_plain got=%h exp=%h", got, exp_o);
        end
    endtask

    task automatic test_load_use();
        out_t held;
        drive(5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL lu_load got=%h exp=%h", got, exp_o);
        end
        drive(5'd8, 5'd9, 5'd10, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (Stall_IFID !== LU_EN) begin
            errors++;
            $display("FAIL lu_stall got=%b exp=%b", Stall_IFID, LU_EN);
        end
        if (LU_EN) begin
            exp_cnt = exp_cnt + 16'd1;
            sb.push_back(bubble(exp_cnt));
        end else begin
            sb.push_back(id_image(exp_cnt));
        end
        held = id_image(exp_cnt);
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL lu_bubble got=%h exp=%h", got, exp_o);
        end
        if (LU_EN) begin
            checks++;
            if (Stall_IFID !== 1'b0) begin
                errors++;
                $display("FAIL lu_release_stall got=%b exp=0", Stall_IFID);
            end
            sb.push_back(held);
            tick();
            exp_o = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL lu_held_load got=%h exp=%h", got, exp_o);
            end
        end
    endtask

    task automatic test_rd_zero();
        drive(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL rd0_load got=%h exp=%h", got, exp_o);
        end
        drive(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (Stall_IFID !== 1'b0) begin
            errors++;
            $display("FAIL rd0_stall got=%b exp=0", Stall_IFID);
        end
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL rd0_next got=%h exp=%h", got, exp_o);
        end
    endtask

    task automatic test_flush_lu();
        drive(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL flush_load got=%h exp=%h", got, exp_o);
        end
        drive(5'd3, 5'd9, 5'd4, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (Stall_IFID !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got=%b exp=0", Stall_IFID);
        end
        sb.push_back(bubble(exp_cnt));
        tick();
        Flush = 1'b0;
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL flush_bubble got=%h exp=%h", got, exp_o);
        end
    endtask

    task automatic test_hold();
        drive(5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0);
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        last  = got;
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL hold_load got=%h exp=%h", got, exp_o);
        end
        last = exp_o;
        for (int i = 0; i < 3; i++) begin
            drive(5'(i + 11), 5'(i + 14), 5'(i + 17), 1'b0, 1'b0, 1'b1);
            #1;
            checks++;
            if (Stall_IFID !== 1'b1) begin
                errors++;
                $display("FAIL hold_stall[%0d] got=%b exp=1", i, Stall_IFID);
            end
            sb.push_back(last);
            tick();
            exp_o = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL hold_frozen[%0d] got=%h exp=%h", i, got, exp_o);
            end
        end
        drive(5'd20, 5'd21, 5'd22, 1'b0, 1'b0, 1'b0);
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL hold_release got=%h exp=%h", got, exp_o);
        end
    endtask

    task automatic test_hold_pending_lu();
        drive(5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0);
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        last  = exp_o;
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL hlu_load got=%h exp=%h", got, exp_o);
        end
        drive(5'd10, 5'd3, 5'd4, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (Stall_IFID !== 1'b1) begin
                errors++;
                $display("FAIL hlu_stall[%0d] got=%b exp=1", i, Stall_IFID);
            end
            sb.push_back(last);
            tick();
            exp_o = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL hlu_frozen[%0d] got=%h exp=%h", i, got, exp_o);
            end
        end
        Hold = 1'b0;
        #1;
        checks++;
        if (Stall_IFID !== LU_EN) begin
            errors++;
            $display("FAIL hlu_unhold_stall got=%b exp=%b", Stall_IFID, LU_EN);
        end
        if (LU_EN) begin
            exp_cnt = exp_cnt + 16'd1;
            sb.push_back(bubble(exp_cnt));
        end else begin
            sb.push_back(id_image(exp_cnt));
        end
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL hlu_bubble got=%h exp=%h", got, exp_o);
        end
    endtask

    task automatic test_saturation();
        if (LU_EN) begin
            // Preload near the ceiling; real hazards then drive it to saturation.
            force dut.cnt_q = 16'hFFFD;
            #1;
            release dut.cnt_q;
            exp_cnt = 16'hFFFD;
        end
        for (int i = 0; i < 4; i++) begin
            drive(5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0);
            sb.push_back(id_image(exp_cnt));
            tick();
            exp_o = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL sat_load[%0d] got=%h exp=%h", i, got, exp_o);
            end
            drive(5'd4, 5'd12, 5'd5, 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (Stall_IFID !== LU_EN) begin
                errors++;
                $display("FAIL sat_stall[%0d] got=%b exp=%b", i, Stall_IFID, LU_EN);
            end
            if (LU_EN) begin
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                sb.push_back(bubble(exp_cnt));
            end else begin
                sb.push_back(id_image(exp_cnt));
            end
            tick();
            exp_o = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL sat_bubble[%0d] got=%h exp=%h", i, got, exp_o);
            end
        end
        checks++;
        if (BubbleCount !== (LU_EN ? 16'hFFFF : 16'h0000)) begin
            errors++;
            $display("FAIL sat_final got=%h exp=%h", BubbleCount,
                     LU_EN ? 16'hFFFF : 16'h0000);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0);
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL mid_load got=%h exp=%h", got, exp_o);
        end
        drive(5'd11, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (Stall_IFID !== LU_EN) begin
            errors++;
            $display("FAIL mid_stall got=%b exp=%b", Stall_IFID, LU_EN);
        end
        #2;
        reset = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h exp=0", got);
        end
        checks++;
        if (Stall_IFID !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_stall got=%b exp=0", Stall_IFID);
        end
        tick();
        reset   = 1'b1;
        exp_cnt = '0;
        drive(5'd6, 5'd7, 5'd8, 1'b0, 1'b0, 1'b0);
        sb.push_back(id_image(exp_cnt));
        tick();
        exp_o = sb.pop_front();
        got   = sample();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL mid_recover got=%h exp=%h", got, exp_o);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_load_use();
        test_rd_zero();
        test_flush_lu();
        test_hold();
        test_hold_pending_lu();
        test_saturation();
        test_reset_mid_stall();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
